// File: rtl/icache_refill_ctrl_pkg.sv
// Shared icache/refill definitions: refill FSM state type, default geometry, and helpers that
// derive beat count and block-offset width from line/beat widths.
package icache_refill_ctrl_pkg;

   localparam int unsigned DEF_ADDR_WIDTH     = 64;
   localparam int unsigned DEF_BLOCK_WIDTH    = 512;
   localparam int unsigned DEF_BEAT_WIDTH     = 64;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

   localparam int unsigned BEAT_COUNT        = DEF_BLOCK_WIDTH / DEF_BEAT_WIDTH;
   localparam int unsigned BLOCK_OFFSET_BITS = $clog2(DEF_BLOCK_WIDTH / 8);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StFill  = 2'd2,
      StWrite = 2'd3
   } refill_state_e;

   function automatic int unsigned beat_count(int unsigned block_w, int unsigned beat_w);
      return block_w / beat_w;
   endfunction

   // Byte-offset bits within one cache line.
   function automatic int unsigned block_offset_bits(int unsigned block_w);
      return $clog2(block_w / 8);
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Memory read bus between the refill controller (master) and memory (slave).
//  mem_req_valid / mem_req_ready / mem_addr : block-aligned read request handshake
//  mem_rvalid / mem_rready / mem_rdata      : read-data beat handshake
interface icache_refill_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned BEAT_WIDTH = 64
);
   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rvalid;
   logic                  mem_rready;
   logic [BEAT_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req_valid,
      input  mem_req_ready,
      output mem_addr,
      input  mem_rvalid,
      output mem_rready,
      input  mem_rdata
   );

   modport slave (
      input  mem_req_valid,
      output mem_req_ready,
      input  mem_addr,
      output mem_rvalid,
      input  mem_rready,
      output mem_rdata
   );
endinterface

// File: rtl/icache_refill_ctrl_line_buffer.sv
// Line assembly buffer: inserts each accepted beat at its slot (beat 0 at the LSBs) and tracks
// the beat index. The index saturates on the last beat instead of wrapping.
//  i_clk, i_arst   clock, asynchronous active-high reset
//  i_clear         restart a line (index and buffer to 0)
//  i_beat_valid    store i_beat_data at the current index
//  i_beat_data     one read beat
//  o_line          assembled line
//  o_last          current index is the final beat of the line
module icache_refill_ctrl_line_buffer
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
   parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_clear,
   input  logic                   i_beat_valid,
   input  logic [BEAT_WIDTH-1:0]  i_beat_data,
   output logic [BLOCK_WIDTH-1:0] o_line,
   output logic                   o_last
);

   localparam int unsigned NUM_BEATS = beat_count(BLOCK_WIDTH, BEAT_WIDTH);
   localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   logic [CNT_W-1:0]       r_cnt;
   logic [BLOCK_WIDTH-1:0] r_line;
   logic                   w_last;

   assign w_last = (r_cnt == CNT_W'(NUM_BEATS - 1));

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_cnt  <= '0;
         r_line <= '0;
      end else if (i_clear) begin
         r_cnt  <= '0;
         r_line <= '0;
      end else if (i_beat_valid) begin
         r_line[r_cnt*BEAT_WIDTH +: BEAT_WIDTH] <= i_beat_data;
         if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_line = r_line;
   assign o_last = w_last;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler. On a fetch miss it latches the address, issues one
// block-aligned read, collects the beats into a full line and pulses the cache write port.
// Fetch is stalled from miss detection until the line is written.
// Optional watchdog: define ICACHE_REFILL_TIMEOUT_EN to abort refills that see no handshake for
// TIMEOUT_CYCLES consecutive cycles (pulses o_refill_err, no write). Without it o_refill_err
// is tied 0 and a refill waits indefinitely.
//  i_clk, i_arst   clock, asynchronous active-high reset
//  i_fetch_req     fetch lookup at i_addr this cycle
//  i_addr          fetch address
//  i_hit           icache hit for o_cache_addr
//  o_stall         fetch must hold/retry
//  o_cache_addr    icache lookup/write address
//  o_write_en      1-cycle icache write strobe
//  o_instr_block   assembled line for the icache
//  o_refill_err    1-cycle pulse when the watchdog aborts a refill
//  mem             memory read bus (master side)
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
   parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH
`ifdef ICACHE_REFILL_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic                   i_clk,
   input  logic                   i_arst,
   input  logic                   i_fetch_req,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic                   i_hit,
   output logic                   o_stall,
   output logic [ADDR_WIDTH-1:0]  o_cache_addr,
   output logic                   o_write_en,
   output logic [BLOCK_WIDTH-1:0] o_instr_block,
   output logic                   o_refill_err,
   icache_refill_ctrl_if.master   mem
);

   localparam int unsigned OFF_BITS = block_offset_bits(BLOCK_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
      ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

   refill_state_e         r_state, w_state_d;
   logic [ADDR_WIDTH-1:0] r_miss_addr, w_miss_addr_d;
   logic                  r_req_valid;
   logic                  r_rready;
   logic                  r_write_en;
   logic                  w_req_fire;
   logic                  w_beat_fire;
   logic                  w_last_beat;

   assign w_req_fire  = r_req_valid & mem.mem_req_ready;
   assign w_beat_fire = r_rready & mem.mem_rvalid;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd;
   logic            r_refill_err;
   logic            w_waiting;
   logic            w_wd_expire;

   // Counts consecutive REQ/FILL cycles with no handshake of either kind.
   assign w_waiting   = (r_state == StReq) || (r_state == StFill);
   assign w_wd_expire = w_waiting && !w_req_fire && !w_beat_fire &&
                        (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_wd         <= '0;
         r_refill_err <= 1'b0;
      end else begin
         r_refill_err <= w_wd_expire;
         if (!w_waiting || w_req_fire || w_beat_fire || w_wd_expire) begin
            r_wd <= '0;
         end else begin
            r_wd <= r_wd + WD_W'(1);
         end
      end
   end

   assign o_refill_err = r_refill_err;
`else
   assign o_refill_err = 1'b0;
`endif

   always_comb begin
      w_state_d     = r_state;
      w_miss_addr_d = r_miss_addr;
      unique case (r_state)
         StIdle: begin
            if (i_fetch_req && !i_hit) begin
               w_miss_addr_d = i_addr;
               w_state_d     = StReq;
            end
         end
         StReq: begin
            if (w_req_fire) w_state_d = StFill;
         end
         StFill: begin
            if (w_beat_fire && w_last_beat) w_state_d = StWrite;
         end
         StWrite: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
`ifdef ICACHE_REFILL_TIMEOUT_EN
      if (w_wd_expire) w_state_d = StIdle;
`endif
   end

   // Bus/strobe outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_state     <= StIdle;
         r_miss_addr <= '0;
         r_req_valid <= 1'b0;
         r_rready    <= 1'b0;
         r_write_en  <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_miss_addr <= w_miss_addr_d;
         r_req_valid <= (w_state_d == StReq);
         r_rready    <= (w_state_d == StFill);
         r_write_en  <= (w_state_d == StWrite);
      end
   end

   icache_refill_ctrl_line_buffer #(
      .BLOCK_WIDTH (BLOCK_WIDTH),
      .BEAT_WIDTH  (BEAT_WIDTH)
   ) u_line_buffer (
      .i_clk        (i_clk),
      .i_arst       (i_arst),
      .i_clear      (w_req_fire),
      .i_beat_valid (w_beat_fire),
      .i_beat_data  (mem.mem_rdata),
      .o_line       (o_instr_block),
      .o_last       (w_last_beat)
   );

   always_comb begin
      if (r_state == StIdle) begin
         o_stall      = i_fetch_req & ~i_hit;
         o_cache_addr = i_addr;
      end else begin
         o_stall      = 1'b1;
         o_cache_addr = r_miss_addr;
      end
   end

   assign o_write_en        = r_write_en;
   assign mem.mem_req_valid = r_req_valid;
   assign mem.mem_rready    = r_rready;
   assign mem.mem_addr      = r_miss_addr & ALIGN_MASK;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: hit path, full refill with cycle-exact write pulse,
// beat gaps, long request back-pressure, reset mid-refill, and (with ICACHE_REFILL_TIMEOUT_EN)
// watchdog abort with TIMEOUT_CYCLES=16.
module tb_icache_refill_ctrl;

   logic         clk = 1'b0;
   logic         arst;
   logic         fetch_req;
   logic [63:0]  addr;
   logic         hit;
   logic         stall;
   logic [63:0]  cache_addr;
   logic         write_en;
   logic [511:0] instr_block;
   logic         refill_err;

   int n_pass  = 0;
   int n_total = 0;
   int n_wr    = 0;

   logic [511:0] exp_blk;
   bit           ok;
   int           wr_before;
   int           w;

   icache_refill_ctrl_if #(.ADDR_WIDTH(64), .BEAT_WIDTH(64)) mem_bus ();

   icache_refill_ctrl #(
      .ADDR_WIDTH  (64),
      .BLOCK_WIDTH (512),
      .BEAT_WIDTH  (64)
`ifdef ICACHE_REFILL_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .i_clk         (clk),
      .i_arst        (arst),
      .i_fetch_req   (fetch_req),
      .i_addr        (addr),
      .i_hit         (hit),
      .o_stall       (stall),
      .o_cache_addr  (cache_addr),
      .o_write_en    (write_en),
      .o_instr_block (instr_block),
      .o_refill_err  (refill_err),
      .mem           (mem_bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (write_en === 1'b1) n_wr++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] beat(input int base, input int k);
      return 64'hC0DE_0000_0000_0000 | 64'(base + k);
   endfunction

   function automatic logic [511:0] line_of(input int base);
      logic [511:0] l;
      for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat(base, k);
      return l;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      arst = 1'b1; fetch_req = 1'b0; addr = '0; hit = 1'b0;
      mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
      tick(); tick();
      chk("rst_write_en", write_en, 0);
      chk("rst_req_valid", mem_bus.mem_req_valid, 0);
      chk("rst_rready", mem_bus.mem_rready, 0);
      chk("rst_refill_err", refill_err, 0);
      chk("rst_block", instr_block, 0);
      arst = 1'b0;
      tick();

      // 1. hit: no stall, no request
      fetch_req = 1'b1; hit = 1'b1; addr = 64'h40;
      #1;
      chk("t1_stall", stall, 0);
      chk("t1_cache_addr", cache_addr, 64'h40);
      tick(); tick();
      chk("t1_no_req", mem_bus.mem_req_valid, 0);

      // 2. miss at 0x1234, immediate ready, 8 back-to-back beats; write at cycle 10
      hit = 1'b0; addr = 64'h1234;
      #1;
      chk("t2_miss_stall", stall, 1);
      wr_before = n_wr;
      tick();                                   // cycle 1: REQ
      hit = 1'b1; addr = 64'h9999;
      #1;
      chk("t2_req_valid", mem_bus.mem_req_valid, 1);
      chk("t2_mem_addr", mem_bus.mem_addr, 64'h1200);
      chk("t2_cache_addr_latched", cache_addr, 64'h1234);
      chk("t2_stall_req", stall, 1);
      mem_bus.mem_req_ready = 1'b1;
      tick();                                   // cycle 2: FILL
      mem_bus.mem_req_ready = 1'b0; fetch_req = 1'b0;
      chk("t2_rready", mem_bus.mem_rready, 1);
      for (int k = 0; k < 8; k++) begin
         mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = beat(0, k);
         if (k == 7) chk("t2_no_write_cycle9", write_en, 0);
         tick();
      end
      mem_bus.mem_rvalid = 1'b0;
      chk("t2_write_cycle10", write_en, 1);
      chk("t2_block", instr_block, line_of(0));
      tick();
      fetch_req = 1'b1; hit = 1'b1; addr = 64'h1234;
      #1;
      chk("t2_write_one_cycle", write_en, 0);
      chk("t2_next_hit_stall", stall, 0);
      chk("t2_write_count", n_wr - wr_before, 1);

      // 3. beat gaps, stray rvalid during REQ, fetch hitting while busy
      hit = 1'b0; addr = 64'h8000_0000_0000_1FC4;
      wr_before = n_wr;
      tick();                                   // REQ
      hit = 1'b1;
      chk("t3_mem_addr", mem_bus.mem_addr, 64'h8000_0000_0000_1FC0);
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      tick();                                   // still REQ, stray beat ignored
      mem_bus.mem_rvalid = 1'b0; mem_bus.mem_req_ready = 1'b1;
      tick();                                   // FILL
      mem_bus.mem_req_ready = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 15; i++) begin
         mem_bus.mem_rvalid = (i % 2 == 0);
         mem_bus.mem_rdata  = beat(16, i / 2);
         #1;
         if (stall !== 1'b1) ok = 1'b0;
         tick();
      end
      mem_bus.mem_rvalid = 1'b0;
      chk("t3_stall_throughout", ok, 1);
      chk("t3_write", write_en, 1);
      chk("t3_block", instr_block, line_of(16));
      tick();
      #1;
      chk("t3_write_count", n_wr - wr_before, 1);
      chk("t3_idle_hit_stall", stall, 0);

      // 4. request back-pressure for 20 cycles
      hit = 1'b0; addr = 64'hFFFF_0000_0000_0ABC;
      tick();                                   // REQ
      hit = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_addr !== 64'hFFFF_0000_0000_0A80)
            ok = 1'b0;
         tick();
      end
      chk("t4_req_stable", ok, 1);
      chk("t4_no_rready_in_req", mem_bus.mem_rready, 0);
      mem_bus.mem_req_ready = 1'b1;
      tick();                                   // FILL
      mem_bus.mem_req_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = beat(32, k);
         tick();
      end
      mem_bus.mem_rvalid = 1'b0;
      w = 0;
      while (write_en !== 1'b1 && w < 8) begin
         tick();
         w++;
      end
      chk("t4_write_seen", write_en, 1);
      chk("t4_block", instr_block, line_of(32));
      tick();

      // 5. reset after beat 3
      hit = 1'b0; addr = 64'h3000;
      wr_before = n_wr;
      tick();                                   // REQ
      hit = 1'b1; mem_bus.mem_req_ready = 1'b1;
      tick();                                   // FILL
      mem_bus.mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = beat(48, k);
         tick();
      end
      mem_bus.mem_rvalid = 1'b0;
      chk("t5_partial_nonzero", instr_block[255:0] != '0, 1);
      arst = 1'b1;
      #2;
      chk("t5_async_block", instr_block, 0);
      chk("t5_async_rready", mem_bus.mem_rready, 0);
      tick(); tick();
      arst = 1'b0;
      fetch_req = 1'b0; addr = 64'h5555;
      #1;
      chk("t5_idle_cache_addr", cache_addr, 64'h5555);
      chk("t5_idle_stall", stall, 0);
      mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 64'h1111;
      for (int i = 0; i < 10; i++) tick();
      mem_bus.mem_rvalid = 1'b0;
      chk("t5_no_write", n_wr - wr_before, 0);
      chk("t5_block_zero", instr_block, 0);
      chk("t5_no_req", mem_bus.mem_req_valid, 0);
      chk("t5_no_err", refill_err, 0);

`ifdef ICACHE_REFILL_TIMEOUT_EN
      // 6. watchdog: no beats after the request handshake
      fetch_req = 1'b1; hit = 1'b0; addr = 64'h7000;
      wr_before = n_wr;
      tick();                                   // REQ
      hit = 1'b1; mem_bus.mem_req_ready = 1'b1;
      tick();                                   // FILL, waiting cycle 1
      mem_bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();      // waiting cycle 16
      chk("t6_no_err_yet", refill_err, 0);
      chk("t6_still_fill", mem_bus.mem_rready, 1);
      tick();
      chk("t6_err_pulse", refill_err, 1);
      chk("t6_idle_rready", mem_bus.mem_rready, 0);
      #1;
      chk("t6_idle_stall", stall, 0);
      tick();
      chk("t6_err_one_cycle", refill_err, 0);
      chk("t6_no_write", n_wr - wr_before, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
